// File: rtl/sram_responder_if.sv
// Control/address side of the asynchronous 16-bit SRAM pin bundle.
// The controller owns the master side and the chip model owns the slave side.
interface sram_responder_if #(
   parameter int ADDR_W = 18
) ();
   logic [ADDR_W-1:0] SRAM_ADDR;
   logic              SRAM_UB_N;
   logic              SRAM_LB_N;
   logic              SRAM_WE_N;
   logic              SRAM_CE_N;
   logic              SRAM_OE_N;

   modport master (
      output SRAM_ADDR,
      output SRAM_UB_N,
      output SRAM_LB_N,
      output SRAM_WE_N,
      output SRAM_CE_N,
      output SRAM_OE_N
   );

   modport slave (
      input SRAM_ADDR,
      input SRAM_UB_N,
      input SRAM_LB_N,
      input SRAM_WE_N,
      input SRAM_CE_N,
      input SRAM_OE_N
   );
endinterface

// File: rtl/sram_responder.sv
// Cycle-based model of a 16-bit async SRAM chip with byte lanes and programmable read latency.
// Optional protocol checker (sticky err output) enabled by macro SRAM_RESP_PROTOCOL_CHECK_EN.
module sram_responder #(
   parameter int ADDR_W   = 18,
   parameter int DEPTH_W  = 10,
   parameter int READ_LAT = 2
) (
   input  logic              clk,
   input  logic              rst,
   sram_responder_if.slave   bus,
   inout  wire  [15:0]       SRAM_DQ,
   output logic              rd_valid,
   output logic [15:0]       wr_count
`ifdef SRAM_RESP_PROTOCOL_CHECK_EN
   ,
   output logic              err
`endif
);

   localparam int         DEPTH      = 1 << DEPTH_W;
   localparam logic [3:0] LAT_RELOAD = 4'(READ_LAT - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT,
      ST_DRIVE
   } state_t;

   state_t              state_reg, state_next;
   logic [3:0]          cnt_reg, cnt_next;
   logic [ADDR_W-1:0]   addr_q_reg, addr_q_next;
   logic [15:0]         wr_count_reg;
   logic [ADDR_W-1:0]   addr;
   logic [1:0]          lane_en;
   logic                is_write;
   logic                is_read;
   logic                dq_oe;
   logic [DEPTH_W-1:0]  wr_idx;
   logic [DEPTH_W-1:0]  rd_idx;

   assign addr     = bus.SRAM_ADDR;
   assign lane_en  = ~{bus.SRAM_UB_N, bus.SRAM_LB_N};
   // Write wins over read whenever WE_N is low, regardless of OE_N.
   assign is_write = !bus.SRAM_CE_N && !bus.SRAM_WE_N;
   assign is_read  = !bus.SRAM_CE_N &&  bus.SRAM_WE_N && !bus.SRAM_OE_N;
   assign dq_oe    = (state_reg == ST_DRIVE);
   assign rd_valid = dq_oe;
   assign wr_count = wr_count_reg;
   assign wr_idx   = addr[DEPTH_W-1:0];
   assign rd_idx   = addr_q_next[DEPTH_W-1:0];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg    <= ST_IDLE;
         cnt_reg      <= '0;
         addr_q_reg   <= '0;
         wr_count_reg <= '0;
      end else begin
         state_reg  <= state_next;
         cnt_reg    <= cnt_next;
         addr_q_reg <= addr_q_next;
         if (is_write && (lane_en != 2'b00)) begin
            wr_count_reg <= wr_count_reg + 16'd1;
         end
      end
   end

   always_comb begin
      state_next  = state_reg;
      cnt_next    = cnt_reg;
      addr_q_next = addr_q_reg;
      if (is_write) begin
         state_next = ST_IDLE;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               if (is_read) begin
                  addr_q_next = addr;
                  cnt_next    = LAT_RELOAD;
                  state_next  = (READ_LAT == 1) ? ST_DRIVE : ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (!is_read) begin
                  state_next = ST_IDLE;
               end else if (addr != addr_q_reg) begin
                  addr_q_next = addr;
                  cnt_next    = LAT_RELOAD;
               end else if (cnt_reg == 4'd0) begin
                  state_next = ST_DRIVE;
               end else begin
                  cnt_next = cnt_reg - 4'd1;
               end
            end
            ST_DRIVE: begin
               if (!is_read) begin
                  state_next = ST_IDLE;
               end else if (addr != addr_q_reg) begin
                  addr_q_next = addr;
                  cnt_next    = LAT_RELOAD;
                  state_next  = ST_WAIT;
               end
            end
            default: begin
               state_next = ST_IDLE;
            end
         endcase
      end
   end

   // One byte-wide RAM per lane; the read port follows the address the FSM will hold next.
   for (genvar gi = 0; gi < 2; gi++) begin : g_lane
      logic [7:0] mem_lane [0:DEPTH-1];
      logic [7:0] rd_byte_reg;

      always_ff @(posedge clk) begin
         if (is_write && lane_en[gi]) begin
            mem_lane[wr_idx] <= SRAM_DQ[gi*8 +: 8];
         end
         rd_byte_reg <= mem_lane[rd_idx];
      end

      assign SRAM_DQ[gi*8 +: 8] = (dq_oe && lane_en[gi]) ? rd_byte_reg : 8'hzz;
   end

`ifdef SRAM_RESP_PROTOCOL_CHECK_EN
   logic err_reg;
   logic contention;
   logic out_of_range;
   logic dq_unknown;

   assign contention   = !bus.SRAM_CE_N && !bus.SRAM_WE_N && !bus.SRAM_OE_N;
   assign out_of_range = (is_write || is_read) && (addr[ADDR_W-1:DEPTH_W] != '0);
`ifndef SYNTHESIS
   assign dq_unknown = is_write &&
                       ((lane_en[1] && $isunknown(SRAM_DQ[15:8])) ||
                        (lane_en[0] && $isunknown(SRAM_DQ[7:0])));
`else
   assign dq_unknown = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         err_reg <= 1'b0;
      end else if (contention || out_of_range || dq_unknown) begin
         err_reg <= 1'b1;
      end
   end

   assign err = err_reg;
`endif

endmodule

// File: tb/tb_sram_responder.sv
// Directed bench for sram_responder: writes, lane masking, latency, restart, async reset.
// The data bus is a pulled-up net, so a released (Z) bus reads back as all ones.
module tb_sram_responder;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   sram_responder_if #(.ADDR_W(18)) bus_if ();

   tri1  [15:0] dq;
   logic [15:0] tb_dq = 16'h0000;
   logic        tb_oe = 1'b0;
   assign dq = tb_oe ? tb_dq : 16'hzzzz;

   logic        rd_valid;
   logic [15:0] wr_count;
`ifdef SRAM_RESP_PROTOCOL_CHECK_EN
   logic        err;
`endif

   int total = 0;
   int bad   = 0;

   sram_responder #(
      .ADDR_W   (18),
      .DEPTH_W  (10),
      .READ_LAT (2)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .bus      (bus_if),
      .SRAM_DQ  (dq),
      .rd_valid (rd_valid),
      .wr_count (wr_count)
`ifdef SRAM_RESP_PROTOCOL_CHECK_EN
      ,
      .err      (err)
`endif
   );

   localparam logic [15:0] RELEASED = 16'hFFFF;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic bus_idle();
      bus_if.SRAM_CE_N = 1'b1;
      bus_if.SRAM_WE_N = 1'b1;
      bus_if.SRAM_OE_N = 1'b1;
      bus_if.SRAM_UB_N = 1'b0;
      bus_if.SRAM_LB_N = 1'b0;
      tb_oe            = 1'b0;
   endtask

   task automatic do_write(input logic [17:0] a, input logic [15:0] d, input logic ub_n, input logic lb_n);
      bus_if.SRAM_ADDR = a;
      bus_if.SRAM_CE_N = 1'b0;
      bus_if.SRAM_WE_N = 1'b0;
      bus_if.SRAM_OE_N = 1'b1;
      bus_if.SRAM_UB_N = ub_n;
      bus_if.SRAM_LB_N = lb_n;
      tb_dq            = d;
      tb_oe            = 1'b1;
      tick();
      bus_idle();
   endtask

   task automatic start_read(input logic [17:0] a, input logic ub_n, input logic lb_n);
      bus_if.SRAM_ADDR = a;
      bus_if.SRAM_CE_N = 1'b0;
      bus_if.SRAM_WE_N = 1'b1;
      bus_if.SRAM_OE_N = 1'b0;
      bus_if.SRAM_UB_N = ub_n;
      bus_if.SRAM_LB_N = lb_n;
      tb_oe            = 1'b0;
   endtask

   initial begin
      bus_if.SRAM_ADDR = '0;
      bus_idle();
      tick();
      tick();
      check("reset_rd_valid", {15'b0, rd_valid}, 16'h0000);
      check("reset_wr_count", wr_count, 16'h0000);
      check("reset_dq", dq, RELEASED);
      rst = 1'b1;

      for (int i = 0; i < 10; i++) begin
         tick();
         check("idle_dq", dq, RELEASED);
         check("idle_rd_valid", {15'b0, rd_valid}, 16'h0000);
         check("idle_wr_count", wr_count, 16'h0000);
      end

      // full-word write, then read with 2-edge latency
      do_write(18'd5, 16'hBEEF, 1'b0, 1'b0);
      check("wr1_count", wr_count, 16'd1);
      start_read(18'd5, 1'b0, 1'b0);
      tick();
      check("rd1_e0_valid", {15'b0, rd_valid}, 16'h0000);
      tick();
      check("rd1_e1_valid", {15'b0, rd_valid}, 16'h0000);
      check("rd1_e1_dq", dq, RELEASED);
      tick();
      check("rd1_e2_valid", {15'b0, rd_valid}, 16'h0001);
      check("rd1_e2_dq", dq, 16'hBEEF);
      check("rd1_wr_count", wr_count, 16'd1);
      bus_idle();
      tick();
      check("rd1_end_valid", {15'b0, rd_valid}, 16'h0000);
      check("rd1_end_dq", dq, RELEASED);

      // upper-lane write, then a no-lane write that must neither store nor count
      do_write(18'd5, 16'h12AB, 1'b0, 1'b1);
      check("wr_upper_count", wr_count, 16'd2);
      do_write(18'd5, 16'h0000, 1'b1, 1'b1);
      check("wr_nolane_count", wr_count, 16'd2);
      do_write(18'd6, 16'hC0DE, 1'b0, 1'b0);
      do_write(18'h00407, 16'h5A5A, 1'b0, 1'b0);
      check("wr_alias_count", wr_count, 16'd4);

      start_read(18'd5, 1'b0, 1'b1);
      tick();
      tick();
      tick();
      check("rd_upper_valid", {15'b0, rd_valid}, 16'h0001);
      check("rd_upper_dq", dq, 16'h12FF);
      bus_if.SRAM_LB_N = 1'b0;
      #1;
      check("rd_full_dq", dq, 16'h12EF);
      bus_idle();
      tick();

      // address change during WAIT restarts the latency
      start_read(18'd5, 1'b0, 1'b0);
      tick();
      check("chg_e0_valid", {15'b0, rd_valid}, 16'h0000);
      bus_if.SRAM_ADDR = 18'd6;
      tick();
      check("chg_e1_valid", {15'b0, rd_valid}, 16'h0000);
      check("chg_e1_dq", dq, RELEASED);
      tick();
      check("chg_e2_valid", {15'b0, rd_valid}, 16'h0000);
      check("chg_e2_dq", dq, RELEASED);
      tick();
      check("chg_e3_valid", {15'b0, rd_valid}, 16'h0001);
      check("chg_e3_dq", dq, 16'hC0DE);

      // address change during DRIVE drops the bus and restarts; 0x407 aliases word 7
      bus_if.SRAM_ADDR = 18'd7;
      tick();
      check("drv_chg_e1_valid", {15'b0, rd_valid}, 16'h0000);
      check("drv_chg_e1_dq", dq, RELEASED);
      tick();
      check("drv_chg_e2_valid", {15'b0, rd_valid}, 16'h0000);
      tick();
      check("drv_chg_e3_valid", {15'b0, rd_valid}, 16'h0001);
      check("alias_dq", dq, 16'h5A5A);

      // asynchronous reset while driving
      #3;
      rst = 1'b0;
      #1;
      check("arst_valid", {15'b0, rd_valid}, 16'h0000);
      check("arst_dq", dq, RELEASED);
      check("arst_wr_count", wr_count, 16'h0000);
      bus_idle();
      tick();
      rst = 1'b1;
      tick();

      start_read(18'd5, 1'b0, 1'b0);
      tick();
      tick();
      tick();
      check("post_rst_valid", {15'b0, rd_valid}, 16'h0001);
      check("post_rst_dq", dq, 16'h12EF);
      bus_idle();
      tick();

`ifdef SRAM_RESP_PROTOCOL_CHECK_EN
      check("err_clear", {15'b0, err}, 16'h0000);
      bus_if.SRAM_ADDR = 18'd9;
      bus_if.SRAM_CE_N = 1'b0;
      bus_if.SRAM_WE_N = 1'b0;
      bus_if.SRAM_OE_N = 1'b0;
      bus_if.SRAM_UB_N = 1'b1;
      bus_if.SRAM_LB_N = 1'b1;
      tb_dq            = 16'h0000;
      tb_oe            = 1'b1;
      tick();
      check("err_set", {15'b0, err}, 16'h0001);
      bus_idle();
      do_write(18'd3, 16'h1111, 1'b0, 1'b0);
      tick();
      check("err_sticky", {15'b0, err}, 16'h0001);
      rst = 1'b0;
      #1;
      check("err_reset", {15'b0, err}, 16'h0000);
      tick();
      rst = 1'b1;
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/sram_responder.md
Name: sram_responder

Overview:
- Synthesizable, cycle-based responder model of the external 16-bit asynchronous SRAM chip, i.e. the device end of the SRAM_* pin bundle driven by the SRAM controller in the memory stage.
- Decodes CE_N/WE_N/OE_N/UB_N/LB_N, stores writes with byte-lane masks, and drives read data onto SRAM_DQ after a programmable latency.
- Used in simulation and on-FPGA loopback benches to exercise the controller's wait/freeze path without the physical chip.

Parameters:
- ADDR_W, 18, width of SRAM_ADDR.
- DEPTH_W, 10, implemented words = 2^DEPTH_W; address bits above DEPTH_W-1 are ignored (aliasing).
- READ_LAT, 2, clock edges from read-request sample to DQ valid; legal range 1..15.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- SRAM_DQ  inout  16  bidirectional data; driven only by this block during read-drive, else Z.
- SRAM_ADDR  in  ADDR_W  word address.
- SRAM_UB_N  in  1  upper byte enable [15:8], active-low.
- SRAM_LB_N  in  1  lower byte enable [7:0], active-low.
- SRAM_WE_N  in  1  write enable, active-low.
- SRAM_CE_N  in  1  chip enable, active-low.
- SRAM_OE_N  in  1  output enable, active-low.
- rd_valid  out  1  high while read data is being driven on SRAM_DQ.
- wr_count  out  16  number of committed write cycles, wraps 16'hFFFF -> 0.

Behaviour:
- Reset (rst=0, async): state=IDLE, latency counter=0, dq_oe=0 (SRAM_DQ all Z), rd_valid=0, wr_count=0. Memory array is not cleared; contents are retained across reset and undefined at power-up.
- Request decode, sampled each rising edge:
  - WRITE = CE_N=0 & WE_N=0, regardless of OE_N. Write has priority.
  - READ = CE_N=0 & WE_N=1 & OE_N=0.
  - otherwise NONE.
- WRITE:
  - On the sampling edge, mem[ADDR[DEPTH_W-1:0]] byte [7:0] <= DQ[7:0] if LB_N=0, and byte [15:8] <= DQ[15:8] if UB_N=0.
  - wr_count increments by 1 if at least one lane is enabled. A write with both lanes disabled stores nothing and does not count.
  - Each clock edge with WRITE asserted is a separate write. The controller holding WE_N low for 3 edges produces 3 writes and +3 on wr_count.
  - dq_oe is forced 0 in the same edge, and the FSM goes to IDLE.
- FSM states: IDLE, WAIT, DRIVE.
  - IDLE -> WAIT on READ: latch addr_q=ADDR, cnt=READ_LAT-1. If READ_LAT=1, go directly to DRIVE instead.
  - WAIT: if READ persists with ADDR==addr_q, decrement cnt; at cnt==0 go to DRIVE.
  - WAIT: if ADDR changes, restart (addr_q=ADDR, cnt reload).
  - WAIT: if READ drops, go to IDLE.
  - DRIVE: dq_oe=1, rd_valid=1. DQ[15:8]=mem[addr_q][15:8] when UB_N=0, else Z; DQ[7:0] likewise with LB_N. Byte masking is combinational on the live UB_N/LB_N.
  - DRIVE -> IDLE when READ drops (dq_oe and rd_valid fall on that edge).
  - DRIVE -> WAIT (restart) if ADDR changes, with dq_oe falling on that edge.
- Read data reflects a write to the same address completed on any earlier edge (read-after-write at the next access).
- Mid-operation reset: the bus is released asynchronously (DQ=Z immediately); the pending read is abandoned.

Optional Feature:
- Macro SRAM_RESP_PROTOCOL_CHECK_EN.
- Defined: adds output port err (1 bit, reset 0). err is sticky and set on any edge where:
  - CE_N=0 & WE_N=0 & OE_N=0 (bus contention), or
  - a WRITE or READ carries ADDR bits above DEPTH_W-1 that are nonzero (out of range), or
  - SRAM_DQ is X/Z on a write-enabled lane (simulation only; excluded from synthesis).
- err clears only on reset.
- Not defined: no err port; contention is resolved silently by write priority.

Test Plan:
- Reset then idle bus (CE_N=1): SRAM_DQ=16'hZZZZ, rd_valid=0, wr_count=0 for 10 cycles.
- Write 16'hBEEF to addr 5 (UB_N=LB_N=0, 1 edge), then READ addr 5 with READ_LAT=2: rd_valid rises exactly 2 edges after the request sample, DQ=16'hBEEF, wr_count=1.
- Byte-lane write 16'h12xx with LB_N=1 to addr 5, then read with UB_N=0/LB_N=1: DQ[15:8]=8'h12, DQ[7:0]=Z. Full-word read returns 16'h12EF.
- Change ADDR from 5 to 6 during WAIT: latency restarts, data of addr 6 appears READ_LAT edges after the change, and addr 5 data is never driven.
- Assert rst=0 during DRIVE: DQ goes Z and rd_valid=0 without a clock edge. After release, read addr 5 still returns 16'h12EF.
- With SRAM_RESP_PROTOCOL_CHECK_EN: CE_N=WE_N=OE_N=0 for one edge -> err=1, remains 1 through subsequent clean traffic until reset.
